instr_encode_writer: RTL and testbench
======================================

Name: instr_encode_writer

Overview:
Field-to-word RV32I instruction encoder and program writer, the write side of the instruction decode path. It accepts per-instruction fields over a valid/ready handshake and packs them into 32-bit words by format (R/I/S/B/U/J). It buffers the words in a 2-entry FIFO and writes them to consecutive word addresses of instruction memory through a stallable write port. Used by the testbench and boot loader to place programs in memory for fetch and decode.

Parameters:
INSTR_WIDTH, 32, encoded instruction width (fixed 32; other values unsupported)
ADDRESS_WIDTH, 5, register-index field width
MEM_ADDR_WIDTH, 16, byte address width of the memory write port
BASE_ADDR, 16'h0000, first write address (word aligned)
LEN_WIDTH, 8, width of the program-length input

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a program load
prog_len  input  LEN_WIDTH  number of instructions to accept; sampled on start
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept a bundle
opcode  input  7  instruction opcode
rd  input  ADDRESS_WIDTH  destination register
rs1  input  ADDRESS_WIDTH  source register 1
rs2  input  ADDRESS_WIDTH  source register 2
funct3  input  3  funct3 field
funct7  input  7  funct7 field (R-type only)
imm  input  32  full immediate; encoder slices it per format
mem_we  output  1  write request
mem_addr  output  MEM_ADDR_WIDTH  write byte address
mem_wdata  output  INSTR_WIDTH  encoded instruction
mem_ready  input  1  memory accepts the write this cycle
done  output  1  load complete; held until next start
err_illegal  output  1  sticky; an unsupported opcode was received in this load
wr_count  output  LEN_WIDTH  instructions written in this load

Behaviour:
- Reset (async, rst_n=0): state IDLE, FIFO emptied, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, done=0, err_illegal=0, wr_count=0, accepted count=0. Reset mid-load abandons the load; no further writes occur.
- States: IDLE, RUN, DONE.
  - IDLE/DONE + start, prog_len!=0: go to RUN; clear mem_addr to BASE_ADDR, wr_count, accepted count, err_illegal and done.
  - IDLE/DONE + start, prog_len=0: go to DONE with done=1 next cycle.
  - RUN: start is ignored. Go to DONE when accepted==prog_len and the FIFO is empty and no write is pending; done=1 in the cycle after the last mem_ready.
- Input handshake:
  - in_ready = (state==RUN) & FIFO not full & (accepted < prog_len).
  - A transfer happens when in_valid & in_ready at a clock edge; accepted increments by 1.
- Encoding is combinational on the input fields; the word is pushed at the accepting edge.
  - R (0110011): {funct7,rs2,rs1,funct3,rd,opcode}
  - I (0010011, 0000011, 1100111): {imm[11:0],rs1,funct3,rd,opcode}
  - S (0100011): {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
  - B (1100011): {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
  - U (0110111, 0010111): {imm[31:12],rd,opcode}
  - J (1101111): {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
  - Unused imm bits are ignored.
- Illegal opcode (any other value): the bundle is still accepted and counts toward prog_len. It is not pushed, and err_illegal is set the next cycle (sticky).
- Write port:
  - mem_we=1 whenever the FIFO is non-empty; mem_wdata = FIFO head.
  - mem_addr, mem_wdata and mem_we stay stable until mem_ready.
  - On mem_we & mem_ready: pop the head, mem_addr += 4 (wraps modulo 2^MEM_ADDR_WIDTH), wr_count += 1.
- Latency: a bundle accepted at edge N gives mem_we=1 with its word from cycle N+1 if the FIFO was empty. Sustained throughput is 1 instruction/cycle when mem_ready=1.
- Simultaneous push and pop in one cycle is allowed; occupancy is unchanged. Push is blocked when full, because in_ready=0.
- Backpressure: if mem_ready=0, the FIFO fills after 2 accepts, then in_ready=0.

Test Plan:
- Reset, start with prog_len=1, addi x1,x0,5 (op 0010011, rd 1, f3 0, imm 5) -> mem_we cycle N+1, mem_addr 0x0000, mem_wdata 0x00500093; done=1 and wr_count=1 after mem_ready.
- prog_len=3, mem_ready=1: add x3,x1,x2; sw x2,8(x1); beq x1,x2,+8 -> writes 0x002081B3@0x0, 0x0020A423@0x4, 0x00208463@0x8 on consecutive cycles.
- prog_len=2, mem_ready=0 for 5 cycles: jal x1,+2048; lui x5,0x12345 -> in_ready low once 2 are buffered; 0x001000EF@0x0 held stable; then 0x123452B7@0x4.
- prog_len=2 with opcode 1111111 then addi -> err_illegal=1, one write 0x00500093@0x0, wr_count=1, done=1.
- Drop rst_n during RUN with a write pending -> mem_we=0 and mem_addr=BASE_ADDR immediately; no writes until the next start. Separately, start with prog_len=0 -> done=1, no writes.
- MEM_ADDR_WIDTH=4, BASE_ADDR=0xC, prog_len=2 -> addresses 0xC, then 0x0 (wrap).

Source files
------------

// File: rtl/instr_encode_writer.sv
// RV32I field-to-word encoder feeding a 2-entry FIFO that writes the encoded
// program to consecutive word addresses through a stallable memory write port.
module instr_encode_writer #(
  parameter int unsigned                 INSTR_WIDTH    = 32,
  parameter int unsigned                 ADDRESS_WIDTH  = 5,
  parameter int unsigned                 MEM_ADDR_WIDTH = 16,
  parameter logic [MEM_ADDR_WIDTH-1:0]   BASE_ADDR      = '0,
  parameter int unsigned                 LEN_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [LEN_WIDTH-1:0]      prog_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [6:0]                opcode,
  input  logic [ADDRESS_WIDTH-1:0]  rd,
  input  logic [ADDRESS_WIDTH-1:0]  rs1,
  input  logic [ADDRESS_WIDTH-1:0]  rs2,
  input  logic [2:0]                funct3,
  input  logic [6:0]                funct7,
  input  logic [31:0]               imm,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [INSTR_WIDTH-1:0]    mem_wdata,
  input  logic                      mem_ready,
  output logic                      done,
  output logic                      err_illegal,
  output logic [LEN_WIDTH-1:0]      wr_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                   state;
  logic [INSTR_WIDTH-1:0]   fifo_mem [2];
  logic                     wptr;
  logic                     rptr;
  logic [1:0]               count;
  logic [1:0]               count_next;
  logic [LEN_WIDTH-1:0]     len_q;
  logic [LEN_WIDTH-1:0]     accepted;
  logic [LEN_WIDTH-1:0]     accepted_next;
  logic [INSTR_WIDTH-1:0]   enc_word;
  logic                     enc_legal;
  logic                     accept;
  logic                     push;
  logic                     pop;

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    unique case (opcode)
      7'b0110011:
        enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      7'b0010011, 7'b0000011, 7'b1100111:
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      7'b0100011:
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      7'b1100011:
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      7'b0110111, 7'b0010111:
        enc_word = {imm[31:12], rd, opcode};
      7'b1101111:
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default:
        enc_legal = 1'b0;
    endcase
  end

  assign in_ready  = (state == S_RUN) && (count != 2'd2) && (accepted < len_q);
  assign accept    = in_valid && in_ready;
  // Illegal bundles are consumed and counted but never reach the FIFO.
  assign push      = accept && enc_legal;
  assign mem_we    = (count != 2'd0);
  assign mem_wdata = fifo_mem[rptr];
  assign pop       = mem_we && mem_ready;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 2'd1;
    else if (pop && !push)
      count_next = count - 2'd1;
  end

  assign accepted_next = accepted + LEN_WIDTH'(accept);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wptr        <= 1'b0;
      rptr        <= 1'b0;
      count       <= '0;
      len_q       <= '0;
      accepted    <= '0;
      mem_addr    <= BASE_ADDR;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      wr_count    <= '0;
    end else begin
      count    <= count_next;
      accepted <= accepted_next;
      if (push) begin
        fifo_mem[wptr] <= enc_word;
        wptr           <= ~wptr;
      end
      if (pop) begin
        rptr     <= ~rptr;
        mem_addr <= mem_addr + MEM_ADDR_WIDTH'(4);
        wr_count <= wr_count + LEN_WIDTH'(1);
      end
      if (accept && !enc_legal)
        err_illegal <= 1'b1;

      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            len_q       <= prog_len;
            accepted    <= '0;
            wr_count    <= '0;
            err_illegal <= 1'b0;
            mem_addr    <= BASE_ADDR;
            done        <= (prog_len == '0);
            state       <= (prog_len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          // Look at post-edge occupancy so done rises right after the last write.
          if ((accepted_next == len_q) && (count_next == 2'd0)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encode_writer.sv
// Randomized and directed checks of instr_encode_writer against a queue-based
// reference model of the encoder, FIFO and write port.
module tb_instr_encode_writer;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start2;
  logic [7:0]  prog_len;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        mem_we, mem_we2;
  logic [15:0] mem_addr;
  logic [3:0]  mem_addr2;
  logic [31:0] mem_wdata, mem_wdata2;
  logic        mem_ready, mem_ready2;
  logic        done, done2;
  logic        err_illegal, err_illegal2;
  logic [7:0]  wr_count, wr_count2;

  int ncmp = 0;
  int nfail = 0;
  bundle_t     prog[$];
  logic [31:0] expq[$];

  always #5 clk = ~clk;

  instr_encode_writer #(.INSTR_WIDTH(32), .ADDRESS_WIDTH(5), .MEM_ADDR_WIDTH(16),
                        .BASE_ADDR(16'h0000), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_len(prog_len),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .rd(rd),
    .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .done(done), .err_illegal(err_illegal),
    .wr_count(wr_count));

  instr_encode_writer #(.INSTR_WIDTH(32), .ADDRESS_WIDTH(5), .MEM_ADDR_WIDTH(4),
                        .BASE_ADDR(4'hC), .LEN_WIDTH(8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start2), .prog_len(prog_len),
    .in_valid(in_valid), .in_ready(in_ready2), .opcode(opcode), .rd(rd),
    .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_ready(mem_ready2), .done(done2), .err_illegal(err_illegal2),
    .wr_count(wr_count2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: {legal, word}, built with shifts and masks from the format tables.
  function automatic logic [32:0] ref_encode(input bundle_t b);
    logic [31:0] w, im, base;
    im   = b.imm;
    base = (32'(b.f3) << 12) | 32'(b.op);
    case (b.op)
      7'h33: w = (32'(b.f7) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15) | base | (32'(b.rd) << 7);
      7'h13, 7'h03, 7'h67:
             w = ((im & 32'hFFF) << 20) | (32'(b.rs1) << 15) | base | (32'(b.rd) << 7);
      7'h23: w = (((im >> 5) & 32'h7F) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15) | base
                 | ((im & 32'h1F) << 7);
      7'h63: w = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(b.rs2) << 20)
                 | (32'(b.rs1) << 15) | base | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7);
      7'h37, 7'h17:
             w = (im & 32'hFFFFF000) | (32'(b.rd) << 7) | 32'(b.op);
      7'h6F: w = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21) | (((im >> 11) & 1) << 20)
                 | (((im >> 12) & 32'hFF) << 12) | (32'(b.rd) << 7) | 32'(b.op);
      default: return {1'b0, 32'h0};
    endcase
    return {1'b1, w};
  endfunction

  function automatic bundle_t mk(input logic [6:0] op, input logic [4:0] rd_i, input logic [4:0] rs1_i,
                                 input logic [4:0] rs2_i, input logic [2:0] f3_i, input logic [31:0] imm_i);
    bundle_t b;
    b.op = op; b.rd = rd_i; b.rs1 = rs1_i; b.rs2 = rs2_i; b.f3 = f3_i; b.f7 = 7'h00; b.imm = imm_i;
    return b;
  endfunction

  function automatic bundle_t rand_bundle();
    logic [6:0] ops [10];
    bundle_t b;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    b.op  = ($urandom_range(9) == 0) ? 7'($urandom) : ops[$urandom_range(8)];
    b.rd  = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
    b.f3  = 3'($urandom); b.f7 = 7'($urandom); b.imm = $urandom;
    return b;
  endfunction

  task automatic apply(input bundle_t b);
    opcode = b.op; rd = b.rd; rs1 = b.rs1; rs2 = b.rs2;
    funct3 = b.f3; funct7 = b.f7; imm = b.imm;
  endtask

  // Runs one load of prog[0:len-1]; mem_ready is held low for hold_low cycles.
  task automatic run_load(input int len, input int valid_pct, input int rdy_pct, input int hold_low);
    int acc = 0, wr = 0;
    bit ill = 0, fin = 0, fire_a, fire_w, exp_rdy;
    logic [32:0] e;
    expq.delete();
    start = 1'b1; prog_len = 8'(len); in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    if (len == 0) begin
      chk("len0_done", done, 1);
      chk("len0_we", mem_we, 0);
      chk("len0_wrcnt", wr_count, 0);
      return;
    end
    chk("start_done", done, 0);
    chk("start_addr", mem_addr, 16'h0000);
    chk("start_wrcnt", wr_count, 0);
    chk("start_err", err_illegal, 0);
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid = (acc < len) && ($urandom_range(99) < valid_pct);
      apply(in_valid ? prog[acc] : rand_bundle());
      mem_ready = (cyc < hold_low) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      exp_rdy = (acc < len) && (expq.size() < 2);
      chk("in_ready", in_ready, exp_rdy);
      chk("mem_we", mem_we, expq.size() != 0);
      if (expq.size() != 0) begin
        chk("mem_wdata", mem_wdata, expq[0]);
        chk("mem_addr", mem_addr, 16'(4 * wr));
      end
      fire_w = (expq.size() != 0) && mem_ready;
      fire_a = in_valid && exp_rdy;
      @(posedge clk); #1;
      if (fire_w) begin
        void'(expq.pop_front());
        wr++;
      end
      if (fire_a) begin
        e = ref_encode(prog[acc]);
        if (e[32]) expq.push_back(e[31:0]);
        else ill = 1;
        acc++;
      end
      chk("err_illegal", err_illegal, ill);
      chk("wr_count", wr_count, 8'(wr));
      if (acc == len && expq.size() == 0) begin
        fin = 1;
        break;
      end
      chk("done_early", done, 0);
    end
    chk("load_timeout", fin, 1);
    chk("done", done, 1);
    in_valid = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; prog_len = '0; in_valid = 1'b0;
    mem_ready = 1'b0; mem_ready2 = 1'b0;
    apply(mk(7'h13, 0, 0, 0, 0, 0));
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_illegal, 0);
    chk("rst_wrcnt", wr_count, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    prog.delete(); prog.push_back(mk(7'h13, 1, 0, 0, 0, 5));
    run_load(1, 100, 100, 0);

    prog.delete();
    prog.push_back(mk(7'h33, 3, 1, 2, 0, 0));
    prog.push_back(mk(7'h23, 0, 1, 2, 2, 8));
    prog.push_back(mk(7'h63, 0, 1, 2, 0, 8));
    run_load(3, 100, 100, 0);

    prog.delete();
    prog.push_back(mk(7'h6F, 1, 0, 0, 0, 32'h800));
    prog.push_back(mk(7'h37, 5, 0, 0, 0, 32'h12345000));
    run_load(2, 100, 100, 5);

    prog.delete();
    prog.push_back(mk(7'h7F, 1, 2, 3, 0, 0));
    prog.push_back(mk(7'h13, 1, 0, 0, 0, 5));
    run_load(2, 100, 100, 0);

    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(12, 1);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back(rand_bundle());
      run_load(n, 40 + 10 * k, 30 + 12 * k, k);
    end

    // Reset while a write is stalled.
    start = 1'b1; prog_len = 8'd2;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; mem_ready = 1'b0;
    apply(mk(7'h13, 1, 0, 0, 0, 5));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_we", mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_addr", mem_addr, 16'h0000);
    chk("mid_rst_ready", in_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    in_valid = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("post_rst_we", mem_we, 0);
      chk("post_rst_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    run_load(0, 0, 0, 0);

    // Address wrap on a 4-bit write port starting at 0xC.
    begin
      int acc2 = 0, wr2 = 0;
      bundle_t wb [2];
      logic [32:0] e;
      logic [3:0] exp_a [2];
      wb[0] = mk(7'h13, 1, 0, 0, 0, 5);
      wb[1] = mk(7'h13, 2, 1, 0, 0, 7);
      exp_a = '{4'hC, 4'h0};
      start2 = 1'b1; prog_len = 8'd2;
      @(posedge clk); #1;
      start2 = 1'b0; mem_ready2 = 1'b1;
      for (int cyc = 0; cyc < 20 && wr2 < 2; cyc++) begin
        in_valid = (acc2 < 2);
        apply(wb[acc2 < 2 ? acc2 : 1]);
        if (mem_we2) begin
          e = ref_encode(wb[wr2]);
          chk("wrap_addr", mem_addr2, exp_a[wr2]);
          chk("wrap_data", mem_wdata2, e[31:0]);
          wr2++;
        end
        if (in_valid && in_ready2) acc2++;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("wrap_writes", wr2, 2);
      chk("wrap_wrcnt", wr_count2, 2);
      chk("wrap_done", done2, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
